// File: rtl/upsample_line_ub.sv
// Streaming nearest-neighbour upsampler with a ping-pong row buffer.
// Each input row lands in one of two banks; a full bank is replayed FACTOR
// times vertically with every pixel repeated FACTOR times horizontally.
module upsample_line_ub #(
    parameter int WIDTH  = 16,
    parameter int IN_W   = 64,
    parameter int IN_H   = 64,
    parameter int FACTOR = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      out_x,
    output logic [15:0]      out_y,
    output logic             out_last
);
    localparam int XW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int FW = (FACTOR > 1) ? $clog2(FACTOR) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IN_W - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FACTOR - 1);
    localparam logic [15:0]   Y_LAST = 16'(IN_H * FACTOR - 1);

    logic [WIDTH-1:0] mem [0:1][0:IN_W-1];
    logic [1:0]       full;
    logic             wbank, rbank;
    logic [XW-1:0]    wx, px;
    logic [FW-1:0]    hrep, vrep;
    logic [15:0]      ox, oy;

    logic wr_en, row_in_done, load, h_wrap, x_wrap, v_wrap;

    assign in_ready    = !full[wbank] && !flush;
    assign wr_en       = in_valid && in_ready;
    assign row_in_done = wr_en && (wx == X_LAST);
    // Output register may be refilled when empty or being drained this cycle.
    assign load        = full[rbank] && (!out_valid || out_ready) && !flush;
    assign h_wrap      = (hrep == F_LAST);
    assign x_wrap      = h_wrap && (px == X_LAST);
    assign v_wrap      = x_wrap && (vrep == F_LAST);

    // Row storage: contents survive reset/flush, only the flags are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wbank][wx] <= in_data;
    end

    // Write-side column counter and bank select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wx    <= '0;
            wbank <= 1'b0;
        end else if (flush) begin
            wx    <= '0;
            wbank <= 1'b0;
        end else if (wr_en) begin
            wx <= (wx == X_LAST) ? '0 : wx + XW'(1);
            if (row_in_done) wbank <= ~wbank;
        end
    end

    // Bank full flags: writer sets a non-full bank, reader clears a full one,
    // so the two updates never target the same bit in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else if (flush) begin
            full <= 2'b00;
        end else begin
            if (row_in_done)     full[wbank] <= 1'b1;
            if (load && v_wrap)  full[rbank] <= 1'b0;
        end
    end

    // Read side: replay counters, frame coordinates and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbank     <= 1'b0;
            px        <= '0;
            hrep      <= '0;
            vrep      <= '0;
            ox        <= '0;
            oy        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else if (flush) begin
            rbank     <= 1'b0;
            px        <= '0;
            hrep      <= '0;
            vrep      <= '0;
            ox        <= '0;
            oy        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mem[rbank][px];
            out_x     <= ox;
            out_y     <= oy;
            out_last  <= v_wrap && (oy == Y_LAST);
            hrep      <= h_wrap ? '0 : hrep + FW'(1);
            ox        <= x_wrap ? '0 : ox + 16'd1;
            if (h_wrap) px <= x_wrap ? '0 : px + XW'(1);
            if (x_wrap) begin
                vrep <= v_wrap ? '0 : vrep + FW'(1);
                oy   <= (oy == Y_LAST) ? '0 : oy + 16'd1;
            end
            if (v_wrap) rbank <= ~rbank;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_upsample_line_ub.sv
// Randomized scoreboard bench for upsample_line_ub.
module tb_upsample_line_ub;
    localparam int W  = 16;
    localparam int IW = 4;
    localparam int IH = 2;
    localparam int F  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last;
    logic [W-1:0]  in_data = '0, out_data;
    logic [15:0]   out_x, out_y;

    logic          b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_last;
    logic [W-1:0]  b_in_data = '0, b_out_data;
    logic [15:0]   b_out_x, b_out_y;

    upsample_line_ub #(.WIDTH(W), .IN_W(IW), .IN_H(IH), .FACTOR(F)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_last(out_last)
    );

    upsample_line_ub #(.WIDTH(W), .IN_W(1), .IN_H(1), .FACTOR(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_x(b_out_x), .out_y(b_out_y), .out_last(b_out_last)
    );

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
        bit          last;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] row_buf[$];
    int          row_idx = 0;
    int          n_cmp = 0, n_err = 0, out_cnt = 0, in_acc = 0, kb = 0;
    int          ro_mode = 0;
    logic        ro_fix = 1'b1;
    exp_t        e_m;

    // Reference: a completed input row expands into FACTOR output rows.
    task automatic model_accept(input logic [15:0] d);
        exp_t e;
        row_buf.push_back(d);
        if (row_buf.size() == IW) begin
            for (int v = 0; v < F; v++)
                for (int c = 0; c < IW * F; c++) begin
                    e.d    = row_buf[c / F];
                    e.x    = c;
                    e.y    = row_idx * F + v;
                    e.last = (row_idx == IH - 1) && (v == F - 1) && (c == IW * F - 1);
                    expq.push_back(e);
                end
            row_buf.delete();
            row_idx = (row_idx + 1) % IH;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Consumer-side ready pattern.
    always @(posedge clk) begin
        #1;
        case (ro_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ro_fix;
        endcase
    end

    // Monitor A: every presented output must match the queue head; pop on accept.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            expq.delete();
            row_buf.delete();
            row_idx = 0;
        end else begin
            if (out_valid) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL out_unexpected: got d=%h x=%0d y=%0d, required no output", out_data, out_x, out_y);
                end else begin
                    e_m = expq[0];
                    if (out_data !== e_m.d || out_x !== 16'(e_m.x) || out_y !== 16'(e_m.y) || out_last !== e_m.last) begin
                        n_err++;
                        $display("FAIL out_pixel: got d=%h x=%0d y=%0d last=%b, required d=%h x=%0d y=%0d last=%b",
                                 out_data, out_x, out_y, out_last, e_m.d, e_m.x, e_m.y, e_m.last);
                    end
                    if (out_ready) void'(expq.pop_front());
                end
                if (out_ready) out_cnt++;
            end
            if (in_valid && in_ready) begin
                in_acc++;
                model_accept(in_data);
            end
        end
    end

    // Monitor B: FACTOR=3 single-pixel frame, output k is at (k%3, k/3).
    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            n_cmp++;
            if (b_out_data !== 16'hABCD || b_out_x !== 16'(kb % 3) || b_out_y !== 16'(kb / 3) || b_out_last !== (kb == 8)) begin
                n_err++;
                $display("FAIL f3_pixel%0d: got d=%h x=%0d y=%0d last=%b, required d=abcd x=%0d y=%0d last=%b",
                         kb, b_out_data, b_out_x, b_out_y, b_out_last, kb % 3, kb / 3, kb == 8);
            end
            kb++;
        end
    end

    task automatic send(input logic [15:0] d);
        int t = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 400);
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept, required accept of %h", d);
        end
    endtask

    task automatic drain();
        int t = 0;
        ro_mode = 0;
        ro_fix  = 1'b1;
        while (expq.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk("drain_queue_empty", expq.size(), 0);
    endtask

    int base_in, base_out;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_xy", {out_x, out_y}, 0);
        chk("rst_out_last", out_last, 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 2x, ready held high
        base_out = out_cnt;
        for (int i = 1; i <= 8; i++) send(16'(i));
        drain();
        chk("basic_count", out_cnt - base_out, 32);

        // Backpressure: ready toggles every cycle
        ro_mode  = 1;
        base_out = out_cnt;
        for (int i = 1; i <= 8; i++) send(16'(i));
        drain();
        chk("bp_count", out_cnt - base_out, 32);

        // Input stall with ready low, then release
        ro_fix = 1'b0;
        @(posedge clk);
        #1;
        base_in  = in_acc;
        base_out = out_cnt;
        fork
            for (int i = 0; i < 12; i++) send(16'(100 + i));
            begin
                int t = 0;
                repeat (20) @(posedge clk);
                #1;
                chk("stall_accepts", in_acc - base_in, 8);
                chk("stall_in_ready", in_ready, 0);
                ro_fix = 1'b1;
                while (out_cnt - base_out < 16 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1;
                chk("stall_release_in_ready", in_ready, 1);
            end
        join
        drain();
        chk("stall_count", out_cnt - base_out, 48);

        // Flush mid-row, then a fresh frame
        base_out = out_cnt;
        send(16'd200);
        send(16'd201);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_out_valid", out_valid, 0);
        flush = 1'b0;
        #0;
        chk("flush_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) send(16'(300 + i));
        drain();
        chk("flush_count", out_cnt - base_out, 32);

        // Random frames with random gaps and random ready
        ro_mode  = 2;
        base_out = out_cnt;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send(16'($urandom));
            end
        drain();
        chk("rand_count", out_cnt - base_out, 128);

        // Asynchronous reset while an output is pending
        ro_fix = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(16'(500 + i));
        repeat (3) @(posedge clk);
        #1;
        chk("prerst_out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_xy", {out_x, out_y}, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        ro_fix = 1'b1;
        @(posedge clk);
        #1;
        base_out = out_cnt;
        for (int i = 0; i < 8; i++) send(16'(600 + i));
        drain();
        chk("postrst_count", out_cnt - base_out, 32);

        // FACTOR=3, 1x1 frame
        b_in_data  = 16'hABCD;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        begin
            int t = 0;
            while (kb < 9 && t < 50) begin
                @(posedge clk);
                t++;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        chk("f3_count", kb, 9);
        chk("f3_out_valid_idle", b_out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
